// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction type, encodings and helpers for the snake core and its key conditioner
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_LEFT  = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_UP    = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    // The encoding puts opposite directions at bitwise complements.
    function automatic dir_t dir_reverse(input dir_t d);
        return ~d;
    endfunction

    function automatic logic [3:0] dir_onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, stability counter and debounced level for one key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic clear_n,
    input  logic key_raw,
    output logic key_level
);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/dir_key_conditioner.sv
// rtl/dir_key_conditioner.sv - debounced key presses to move-tick aligned direction; DIR_QUEUE_EN selects a 2-entry turn FIFO
module dir_key_conditioner
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [3:0] key_raw,
    input  logic       move_tick,
    output logic [1:0] dir_code,
    output logic [3:0] direction,
    output logic       turn_applied
);

    logic [3:0] key_level;
    logic [3:0] prev_q;
    logic [3:0] press;
    logic       press_any;
    dir_t       win;
    dir_t       dir_q, dir_d;
    logic       turn_q, turn_d;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_key (
            .clk      (clk),
            .clear_n  (clear_n),
            .key_raw  (key_raw[k]),
            .key_level(key_level[k])
        );
    end

    assign press     = key_level & ~prev_q;
    assign press_any = |press;

    always_comb begin
        win = DIR_UP;
        if (press[3])      win = DIR_RIGHT;
        else if (press[0]) win = DIR_LEFT;
        else if (press[1]) win = DIR_DOWN;
    end

`ifdef DIR_QUEUE_EN
    logic [1:0] fcnt_q, fcnt_d;
    dir_t       q0_q, q0_d, q1_q, q1_d;
    dir_t       tail_ref;
    logic       accept;

    always_comb begin
        dir_d  = dir_q;
        turn_d = 1'b0;
        fcnt_d = fcnt_q;
        q0_d   = q0_q;
        q1_d   = q1_q;
        // Presses are vetted against the direction they would follow, before any pop this cycle.
        if (fcnt_q == 2'd0)      tail_ref = dir_q;
        else if (fcnt_q == 2'd1) tail_ref = q0_q;
        else                     tail_ref = q1_q;
        accept = press_any && (win != tail_ref) && (win != dir_reverse(tail_ref));
        if (move_tick && fcnt_q != 2'd0) begin
            if (q0_q != dir_q) begin
                dir_d  = q0_q;
                turn_d = 1'b1;
            end
            q0_d   = q1_q;
            fcnt_d = fcnt_q - 2'd1;
        end
        if (accept) begin
            if (fcnt_d == 2'd0) begin
                q0_d   = win;
                fcnt_d = 2'd1;
            end else begin
                q1_d   = win;
                fcnt_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            fcnt_q <= 2'd0;
            q0_q   <= DIR_RIGHT;
            q1_q   <= DIR_RIGHT;
        end else begin
            fcnt_q <= fcnt_d;
            q0_q   <= q0_d;
            q1_q   <= q1_d;
        end
    end
`else
    logic pend_valid_q, pend_valid_d;
    dir_t pend_code_q, pend_code_d;

    always_comb begin
        dir_d        = dir_q;
        turn_d       = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        if (move_tick && pend_valid_q) begin
            if (pend_code_q != dir_q && pend_code_q != dir_reverse(dir_q)) begin
                dir_d  = pend_code_q;
                turn_d = 1'b1;
            end
            pend_valid_d = 1'b0;
        end
        // A press coinciding with the tick waits for the following tick.
        if (press_any) begin
            pend_valid_d = 1'b1;
            pend_code_d  = win;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pend_valid_q <= 1'b0;
            pend_code_q  <= DIR_RIGHT;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            prev_q <= 4'b0000;
            dir_q  <= DIR_RIGHT;
            turn_q <= 1'b0;
        end else begin
            prev_q <= key_level;
            dir_q  <= dir_d;
            turn_q <= turn_d;
        end
    end

    assign dir_code     = dir_q;
    assign direction    = dir_onehot(dir_q);
    assign turn_applied = turn_q;

endmodule
